spi_reg_ctrl: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_reg_bank.sv | 45 ++++
 rtl/spi_reg_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg: shared types and constants for the SPI register controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int         CMD_WR_BIT        = 7;
  localparam logic [6:0] STATUS_ID_DEFAULT = 7'h25;
  localparam logic [7:0] ERR_FILL          = 8'h00;

endpackage

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank: register array with write decode, read mux and flat export. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_bank #(
  parameter int REG_W  = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [REG_W-1:0]        wr_data_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [REG_W-1:0]        rd_data_o,
  output logic [NREGS*REG_W-1:0]  regs_flat_o
);

  logic [REG_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
          regs_q[i] <= wr_data_i;
        end
      end
    end
  end

  assign rd_data_o = regs_q[rd_addr_i];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat_o[g*REG_W +: REG_W] = regs_q[g];
  end

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl: parses SPI frames (command byte + data bytes) into register
// writes and streams register contents back on the transmit byte. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         REG_W     = 32,
  parameter int         NREGS     = 8,
  parameter int         ADDR_W    = 3,
  parameter logic [6:0] STATUS_ID = STATUS_ID_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [7:0]             tx_data,
  output logic                   reg_wr_stb,
  output logic [ADDR_W-1:0]      reg_wr_addr,
  output logic [REG_W-1:0]       reg_wr_data,
  output logic                   rd_stb,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [NREGS*REG_W-1:0] regs_flat,
  output logic                   err_sticky
);

  localparam int NB   = REG_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

  state_e              state_q, state_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [REG_W-1:0]    acc_q, acc_d;
  logic [REG_W-1:0]    shadow_q, shadow_d;
  logic [7:0]          tx_q, tx_d;
  logic                err_q, err_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [REG_W-1:0]    wr_data_q, wr_data_d;
  logic                rd_stb_q, rd_stb_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic                w_bank_wr_en;
  logic [ADDR_W-1:0]   w_bank_rd_addr;
  logic [REG_W-1:0]    w_bank_rd_data;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [REG_W-1:0]    w_acc_nxt;
  logic [REG_W-1:0]    w_shadow_sh;
  logic                w_last_byte;
  logic                w_bad_addr;

  assign w_addr_inc  = (cur_addr_q == ADDR_W'(NREGS - 1)) ? '0 : cur_addr_q + 1'b1;
  assign w_acc_nxt   = (acc_q << 8) | REG_W'(rx_data);
  assign w_shadow_sh = shadow_q << 8;
  assign w_last_byte = (byte_idx_q == BI_W'(NB - 1));
  assign w_bad_addr  = ({1'b0, rx_data[6:0]} >= 8'(NREGS));

  // The command byte selects the register to snapshot; afterwards the read
  // mux looks ahead to the next sequential register.
  assign w_bank_rd_addr = (state_q == CMD) ? rx_data[ADDR_W-1:0] : w_addr_inc;

  spi_reg_bank #(
    .REG_W  (REG_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (w_bank_wr_en),
    .wr_addr_i   (cur_addr_q),
    .wr_data_i   (w_acc_nxt),
    .rd_addr_i   (w_bank_rd_addr),
    .rd_data_o   (w_bank_rd_data),
    .regs_flat_o (regs_flat)
  );

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    cur_addr_d   = cur_addr_q;
    acc_d        = acc_q;
    shadow_d     = shadow_q;
    tx_d         = tx_q;
    err_d        = err_q;
    wr_stb_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_stb_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    w_bank_wr_en = 1'b0;

    if (frame_start) begin
      state_d    = CMD;
      byte_idx_d = '0;
      tx_d       = {err_q, STATUS_ID};
    end else begin
      if (rx_valid) begin
        unique case (state_q)
          CMD: begin
            byte_idx_d = '0;
            if (w_bad_addr) begin
              state_d = ERR;
              err_d   = 1'b1;
              tx_d    = ERR_FILL;
            end else begin
              err_d      = 1'b0;
              cur_addr_d = rx_data[ADDR_W-1:0];
              if (rx_data[CMD_WR_BIT]) begin
                state_d = WR;
                tx_d    = ERR_FILL;
              end else begin
                state_d   = RD;
                shadow_d  = w_bank_rd_data;
                tx_d      = w_bank_rd_data[REG_W-1 -: 8];
                rd_stb_d  = 1'b1;
                rd_addr_d = rx_data[ADDR_W-1:0];
              end
            end
          end
          WR: begin
            tx_d = ERR_FILL;
            if (w_last_byte) begin
              w_bank_wr_en = 1'b1;
              wr_stb_d     = 1'b1;
              wr_addr_d    = cur_addr_q;
              wr_data_d    = w_acc_nxt;
              cur_addr_d   = w_addr_inc;
              byte_idx_d   = '0;
            end else begin
              acc_d      = w_acc_nxt;
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
          RD: begin
            if (w_last_byte) begin
              cur_addr_d = w_addr_inc;
              shadow_d   = w_bank_rd_data;
              tx_d       = w_bank_rd_data[REG_W-1 -: 8];
              rd_stb_d   = 1'b1;
              rd_addr_d  = w_addr_inc;
              byte_idx_d = '0;
            end else begin
              shadow_d   = w_shadow_sh;
              tx_d       = w_shadow_sh[REG_W-1 -: 8];
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      // A byte landing with frame_end is processed above before going idle.
      if (frame_end) begin
        state_d = IDLE;
        tx_d    = {err_d, STATUS_ID};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      cur_addr_q <= '0;
      acc_q      <= '0;
      shadow_q   <= '0;
      tx_q       <= {1'b0, STATUS_ID};
      err_q      <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_stb_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      cur_addr_q <= cur_addr_d;
      acc_q      <= acc_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_stb_q   <= rd_stb_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign tx_data     = tx_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign rd_stb      = rd_stb_q;
  assign rd_addr     = rd_addr_q;
  assign err_sticky  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl: frame-level reference model bench for spi_reg_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_ctrl;

  localparam int         REG_W  = 32;
  localparam int         NREGS  = 8;
  localparam int         ADDR_W = 3;
  localparam int         NB     = REG_W / 8;
  localparam logic [6:0] SID    = 7'h25;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   frame_start = 1'b0;
  logic                   frame_end = 1'b0;
  logic                   rx_valid = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic [7:0]             tx_data;
  logic                   reg_wr_stb;
  logic [ADDR_W-1:0]      reg_wr_addr;
  logic [REG_W-1:0]       reg_wr_data;
  logic                   rd_stb;
  logic [ADDR_W-1:0]      rd_addr;
  logic [NREGS*REG_W-1:0] regs_flat;
  logic                   err_sticky;

  spi_reg_ctrl #(
    .REG_W     (REG_W),
    .NREGS     (NREGS),
    .ADDR_W    (ADDR_W),
    .STATUS_ID (SID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .rd_stb      (rd_stb),
    .rd_addr     (rd_addr),
    .regs_flat   (regs_flat),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [REG_W-1:0] m_regs [NREGS];
  logic             m_err;

  // Observed strobes
  int unsigned      got_wr_a[$];
  logic [REG_W-1:0] got_wr_d[$];
  int unsigned      got_rd[$];

  always @(negedge clk) begin
    if (reg_wr_stb) begin
      got_wr_a.push_back(int'(reg_wr_addr));
      got_wr_d.push_back(reg_wr_data);
    end
    if (rd_stb) got_rd.push_back(int'(rd_addr));
  end

  logic [7:0] fbytes[$];

  function automatic logic [255:0] model_flat();
    logic [255:0] f = '0;
    for (int i = 0; i < NREGS; i++) f[i*REG_W +: REG_W] = m_regs[i];
    return f;
  endfunction

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    frame_start = 1'b1;
    rx_valid    = with_byte;
    rx_data     = b;
    @(negedge clk);
    frame_start = 1'b0;
    rx_valid    = 1'b0;
  endtask

  task automatic run_frame(input bit coinc_end, input bit junk_start);
    logic [7:0]       exp_tx;
    logic [7:0]       b;
    int               mode;
    int               cur;
    int               cnt;
    logic [REG_W-1:0] acc;
    logic [REG_W-1:0] snap;
    int unsigned      exp_wr_a[$];
    logic [REG_W-1:0] exp_wr_d[$];
    int unsigned      exp_rd[$];
    mode = 0; cur = 0; cnt = 0; acc = '0; snap = '0;
    got_wr_a.delete(); got_wr_d.delete(); got_rd.delete();
    pulse_start(junk_start, 8'h83);
    exp_tx = {m_err, SID};
    for (int i = 0; i < fbytes.size(); i++) begin
      b = fbytes[i];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("tx_byte", tx_data, exp_tx);
      rx_valid = 1'b1;
      rx_data  = b;
      if (coinc_end && (i == fbytes.size() - 1)) frame_end = 1'b1;
      @(negedge clk);
      rx_valid  = 1'b0;
      frame_end = 1'b0;
      if (i == 0) begin
        if (int'(b[6:0]) >= NREGS) begin
          mode = 0; m_err = 1'b1; exp_tx = 8'h00;
        end else begin
          m_err = 1'b0; cur = int'(b[6:0]); cnt = 0;
          if (b[7]) begin
            mode = 1; exp_tx = 8'h00; acc = '0;
          end else begin
            mode = 2; snap = m_regs[cur]; exp_rd.push_back(cur);
            exp_tx = 8'(snap >> (8 * (NB - 1)));
          end
        end
      end else if (mode == 1) begin
        acc = (acc << 8) | REG_W'(b);
        cnt++;
        if (cnt == NB) begin
          m_regs[cur] = acc;
          exp_wr_a.push_back(cur);
          exp_wr_d.push_back(acc);
          cur = (cur + 1) % NREGS;
          cnt = 0;
        end
      end else if (mode == 2) begin
        cnt++;
        if (cnt == NB) begin
          cur = (cur + 1) % NREGS;
          cnt = 0;
          snap = m_regs[cur];
          exp_rd.push_back(cur);
        end
        exp_tx = 8'(snap >> (8 * (NB - 1 - cnt)));
      end
    end
    if (!(coinc_end && fbytes.size() > 0)) begin
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("tx_idle", tx_data, {m_err, SID});
    check("err_sticky", err_sticky, m_err);
    check("regs_flat", regs_flat, model_flat());
    check("wr_count", got_wr_a.size(), exp_wr_a.size());
    for (int k = 0; k < exp_wr_a.size() && k < got_wr_a.size(); k++) begin
      check("wr_addr", got_wr_a[k], exp_wr_a[k]);
      check("wr_data", got_wr_d[k], exp_wr_d[k]);
    end
    check("rd_count", got_rd.size(), exp_rd.size());
    for (int k = 0; k < exp_rd.size() && k < got_rd.size(); k++) begin
      check("rd_addr", got_rd[k], exp_rd[k]);
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", tx_data, 8'h25);
    check("rst_regs", regs_flat, '0);
    check("rst_err", err_sticky, 1'b0);
    check("rst_stb", {reg_wr_stb, rd_stb}, 2'b00);

    // Directed: write reg2, read it back across the reg3 boundary
    fbytes = '{8'h82, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(1'b0, 1'b0);
    check("reg2_const", regs_flat[2*REG_W +: REG_W], 32'h12345678);
    fbytes = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(1'b0, 1'b0);

    // Wrap from reg7 to reg0, final byte coincident with frame_end
    fbytes = '{8'h87, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h55, 8'h55};
    run_frame(1'b1, 1'b0);
    check("reg7_const", regs_flat[7*REG_W +: REG_W], 32'hAAAAAAAA);
    check("reg0_const", regs_flat[0 +: REG_W], 32'h55555555);

    // Bad address then status read-to-clear
    fbytes = '{8'h10, 8'h01, 8'h02, 8'h03};
    run_frame(1'b0, 1'b0);
    check("err_status", tx_data, 8'hA5);
    fbytes = '{8'h03};
    run_frame(1'b0, 1'b0);
    check("err_cleared", tx_data, 8'h25);

    // Partial write discarded; frame_start swallowing a byte
    fbytes = '{8'h81, 8'hDE, 8'hAD};
    run_frame(1'b0, 1'b0);
    fbytes = '{8'h01, 8'h00, 8'h00};
    run_frame(1'b0, 1'b1);

    // Reset during a write
    got_wr_a.delete();
    pulse_start(1'b0, 8'h00);
    foreach (fbytes[i]) fbytes[i] = 8'h00;
    fbytes = '{8'h81, 8'h9A, 8'hBC, 8'hDE};
    foreach (fbytes[i]) begin
      rx_valid = 1'b1; rx_data = fbytes[i];
      @(negedge clk);
      rx_valid = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_tx", tx_data, 8'h25);
    check("mid_rst_regs", regs_flat, model_flat());
    check("mid_rst_nostb", got_wr_a.size(), 0);

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      int len;
      logic [7:0] cmd;
      cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, NREGS + 3))};
      len = $urandom_range(0, 3 * NB);
      fbytes = '{cmd};
      for (int j = 0; j < len; j++) fbytes.push_back(8'($urandom_range(0, 255)));
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
